// File: rtl/encoder_cmd_scheduler.sv
// Command scheduler and edit-mode controller in front of the rotary-encoder BCD counter.
// Merges encoder step pulses and two held push-buttons (with auto-repeat) into a signed
// pending-step accumulator. A LOCKED/EDIT state machine decides whether those steps are
// accepted. Pending steps drain as paced single-cycle strobes to the counter.
//
// Ports:
//   clk_in       system clock
//   rst_n_in     asynchronous active-low reset
//   enc_left     encoder step down (1-cycle pulse)
//   enc_right    encoder step up (1-cycle pulse)
//   enc_press    encoder push (1-cycle pulse), toggles LOCKED/EDIT
//   key_up       debounced level, held = step up with auto-repeat
//   key_down     debounced level, held = step down with auto-repeat
//   Left_pulse   1-cycle decrement strobe to the counter
//   Right_pulse  1-cycle increment strobe to the counter
//   d_pulse      high while in EDIT (decimal-point indicator)
//   edit_mode    high while in EDIT
//   pend_ovf     sticky flag: a step was clipped by accumulator saturation
module encoder_cmd_scheduler #(
  parameter int unsigned HOLD_DLY   = 6000000,
  parameter int unsigned REPEAT_PER = 1200000,
  parameter int unsigned GAP        = 4,
  parameter int unsigned MAX_PEND   = 7,
  parameter int unsigned IDLE_TO    = 120000000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic enc_left,
  input  logic enc_right,
  input  logic enc_press,
  input  logic key_up,
  input  logic key_down,
  output logic Left_pulse,
  output logic Right_pulse,
  output logic d_pulse,
  output logic edit_mode,
  output logic pend_ovf
);

  localparam int unsigned PW = $clog2(MAX_PEND + 1) + 1;
  localparam int unsigned SW = PW + 2;
  localparam int unsigned KW = $clog2(HOLD_DLY + REPEAT_PER + 1);
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam int unsigned IW = $clog2(IDLE_TO + 1);

  localparam logic signed [SW-1:0] PMAX_S = SW'(MAX_PEND);
  localparam logic signed [PW-1:0] PMAX_P = PW'(MAX_PEND);

  typedef enum logic {StLocked, StEdit} state_t;

  state_t                state_q, state_d;
  logic signed [PW-1:0]  pend_q, pend_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [IW-1:0]         idle_q, idle_d;
  logic                  ovf_q, ovf_d;
  logic                  left_q, right_q;

  // Per-key state, index 0 = key_up, index 1 = key_down.
  logic [1:0]            key_eff;
  logic [1:0]            key_prev_q;
  logic [1:0]            key_rep_q, key_rep_d;
  logic [1:0][KW-1:0]    key_cnt_q, key_cnt_d;
  logic [1:0]            key_fire;
  logic [KW-1:0]         key_lim;

  logic                  in_edit, timeout, stay, issue_up, issue_dn;
  logic signed [SW-1:0]  net_s, acc_s, iss_s, pend_ext, sum_s;

  // Key step generation. A key only counts as pressed while the other one is released,
  // so holding both suppresses steps and a key left held afterwards sees a fresh edge.
  // key_cnt holds the number of cycles since the last step of that key.
  always_comb begin
    key_eff   = {key_down & ~key_up, key_up & ~key_down};
    key_fire  = '0;
    key_cnt_d = key_cnt_q;
    key_rep_d = key_rep_q;
    key_lim   = '0;
    for (int k = 0; k < 2; k++) begin
      key_lim = key_rep_q[k] ? KW'(REPEAT_PER) : KW'(HOLD_DLY);
      if (!key_eff[k]) begin
        key_cnt_d[k] = '0;
        key_rep_d[k] = 1'b0;
      end else if (!key_prev_q[k]) begin
        key_fire[k]  = 1'b1;
        key_cnt_d[k] = KW'(1);
        key_rep_d[k] = 1'b0;
      end else if (key_cnt_q[k] == key_lim) begin
        key_fire[k]  = 1'b1;
        key_cnt_d[k] = KW'(1);
        key_rep_d[k] = 1'b1;
      end else begin
        key_cnt_d[k] = key_cnt_q[k] + KW'(1);
      end
    end
  end

  // Mode FSM, issuer and accumulator.
  always_comb begin
    in_edit = (state_q == StEdit);

    net_s = '0;
    if (enc_right)   net_s = net_s + SW'(1);
    if (enc_left)    net_s = net_s - SW'(1);
    if (key_fire[0]) net_s = net_s + SW'(1);
    if (key_fire[1]) net_s = net_s - SW'(1);
    acc_s = in_edit ? net_s : '0;

    timeout = in_edit && (acc_s == '0) && (idle_q == IW'(IDLE_TO - 1));

    state_d = state_q;
    if (enc_press) begin
      state_d = in_edit ? StLocked : StEdit;
    end else if (timeout) begin
      state_d = StLocked;
    end
    stay = in_edit && (state_d == StEdit);

    // No new strobe is launched on the edge that leaves EDIT.
    issue_up = stay && (gap_q == '0) && !pend_q[PW-1] && (pend_q != '0);
    issue_dn = stay && (gap_q == '0) && pend_q[PW-1];
    iss_s = '0;
    if (issue_up) iss_s = SW'(1);
    if (issue_dn) iss_s = -SW'(1);

    pend_ext = {{2{pend_q[PW-1]}}, pend_q};
    sum_s    = pend_ext - iss_s + acc_s;

    ovf_d = ovf_q;
    if (sum_s > PMAX_S) begin
      pend_d = PMAX_P;
      if (acc_s != '0) ovf_d = 1'b1;
    end else if (sum_s < -PMAX_S) begin
      pend_d = -PMAX_P;
      if (acc_s != '0) ovf_d = 1'b1;
    end else begin
      pend_d = sum_s[PW-1:0];
    end

    if (state_d != StEdit) pend_d = '0;
    if (!in_edit && (state_d == StEdit)) ovf_d = 1'b0;

    if (issue_up || issue_dn) begin
      gap_d = GW'(GAP - 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end else begin
      gap_d = gap_q;
    end

    // Idle timer counts up from zero; it restarts on entry and on every accepted step.
    if (stay && (acc_s == '0)) begin
      idle_d = idle_q + IW'(1);
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StLocked;
      pend_q     <= '0;
      gap_q      <= '0;
      idle_q     <= '0;
      ovf_q      <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      key_prev_q <= '0;
      key_rep_q  <= '0;
      key_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      gap_q      <= gap_d;
      idle_q     <= idle_d;
      ovf_q      <= ovf_d;
      left_q     <= issue_dn;
      right_q    <= issue_up;
      key_prev_q <= key_eff;
      key_rep_q  <= key_rep_d;
      key_cnt_q  <= key_cnt_d;
    end
  end

  assign Left_pulse  = left_q;
  assign Right_pulse = right_q;
  assign edit_mode   = (state_q == StEdit);
  assign d_pulse     = (state_q == StEdit);
  assign pend_ovf    = ovf_q;

endmodule

// File: tb/tb_encoder_cmd_scheduler.sv
// Bench for encoder_cmd_scheduler: a table of directed vectors, hand-written sequences for
// the multi-cycle cases, and randomized stimulus checked every cycle against a behavioural
// model built from step counts, hold durations and a pending-step integer.
module tb_encoder_cmd_scheduler;

  localparam int HOLD_DLY   = 10;
  localparam int REPEAT_PER = 4;
  localparam int GAP        = 4;
  localparam int MAX_PEND   = 3;
  localparam int IDLE_TO    = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enc_left = 1'b0, enc_right = 1'b0, enc_press = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic Left_pulse, Right_pulse, d_pulse, edit_mode, pend_ovf;

  encoder_cmd_scheduler #(
    .HOLD_DLY  (HOLD_DLY),
    .REPEAT_PER(REPEAT_PER),
    .GAP       (GAP),
    .MAX_PEND  (MAX_PEND),
    .IDLE_TO   (IDLE_TO)
  ) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .enc_left   (enc_left),
    .enc_right  (enc_right),
    .enc_press  (enc_press),
    .key_up     (key_up),
    .key_down   (key_down),
    .Left_pulse (Left_pulse),
    .Right_pulse(Right_pulse),
    .d_pulse    (d_pulse),
    .edit_mode  (edit_mode),
    .pend_ovf   (pend_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_right = 0;
  int n_left = 0;

  // Behavioural model state.
  bit m_edit, m_ovf, e_l, e_r;
  int m_pend, m_gap, m_quiet, m_up_held, m_dn_held;

  typedef struct {
    bit l, r, p;
    bit el, er, ed, eo;
  } vec_t;
  vec_t tbl[26];

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {L,R,edit,d,ovf}=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic bit key_fires(input int held);
    return held == 0 || held == HOLD_DLY ||
           (held > HOLD_DLY && (held - HOLD_DLY) % REPEAT_PER == 0);
  endfunction

  task automatic model_reset();
    m_edit = 0; m_ovf = 0; e_l = 0; e_r = 0;
    m_pend = 0; m_gap = 0; m_quiet = 0; m_up_held = 0; m_dn_held = 0;
  endtask

  // Advances the model by one clock for the given inputs; e_* hold the values expected
  // on the outputs after the edge.
  task automatic model_step(input bit l, input bit r, input bit p, input bit ku, input bit kd);
    int ks, acc, iss, sum;
    bit leave, enter;
    ks = 0;
    if (ku && !kd) begin
      if (key_fires(m_up_held)) ks++;
      m_up_held++;
    end else m_up_held = 0;
    if (kd && !ku) begin
      if (key_fires(m_dn_held)) ks--;
      m_dn_held++;
    end else m_dn_held = 0;
    acc = m_edit ? (int'(r) - int'(l) + ks) : 0;
    leave = m_edit && (p || (acc == 0 && m_quiet == IDLE_TO - 1));
    enter = !m_edit && p;
    iss = 0;
    if (m_edit && !leave && m_gap == 0) iss = (m_pend > 0) ? 1 : ((m_pend < 0) ? -1 : 0);
    sum = m_pend - iss + acc;
    if (sum > MAX_PEND) begin sum = MAX_PEND; m_ovf = 1; end
    else if (sum < -MAX_PEND) begin sum = -MAX_PEND; m_ovf = 1; end
    m_gap = (iss != 0) ? GAP - 1 : ((m_gap > 0) ? m_gap - 1 : 0);
    if (m_edit && !leave) m_quiet = (acc != 0) ? 0 : m_quiet + 1;
    else m_quiet = 0;
    if (leave) begin m_edit = 0; sum = 0; end
    if (enter) begin m_edit = 1; m_ovf = 0; end
    m_pend = sum;
    e_r = (iss > 0);
    e_l = (iss < 0);
  endtask

  task automatic cycle(input bit l, input bit r, input bit p, input bit ku, input bit kd);
    enc_left = l; enc_right = r; enc_press = p; key_up = ku; key_down = kd;
    model_step(l, r, p, ku, kd);
    @(posedge clk);
    #1;
    check("model", {Left_pulse, Right_pulse, edit_mode, d_pulse, pend_ovf},
          {e_l, e_r, m_edit, m_edit, m_ovf});
    n_right += int'(Right_pulse);
    n_left  += int'(Left_pulse);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    int cnt, ku_s, kd_s;
    bit seen;

    for (int i = 0; i < 26; i++) begin
      tbl[i].l  = 0;
      tbl[i].r  = (i < 3) || (i == 4) || (i >= 10 && i <= 14);
      tbl[i].p  = (i == 3);
      tbl[i].el = 0;
      tbl[i].er = (i == 5) || (i == 11) || (i == 15) || (i == 19) || (i == 23);
      tbl[i].ed = (i >= 3);
      tbl[i].eo = (i >= 14);
    end

    model_reset();
    #2;
    check("reset_outputs", {Left_pulse, Right_pulse, edit_mode, d_pulse, pend_ovf}, 5'b0);
    #21 rst_n = 1'b1;

    // Locked steps ignored, entry on press, single-step latency, saturation burst.
    for (int i = 0; i < 26; i++) begin
      cycle(tbl[i].l, tbl[i].r, tbl[i].p, 0, 0);
      check($sformatf("table_row%0d", i),
            {Left_pulse, Right_pulse, edit_mode, d_pulse, pend_ovf},
            {tbl[i].el, tbl[i].er, tbl[i].ed, tbl[i].ed, tbl[i].eo});
    end

    // key_up held 20 cycles: steps at +0, +10, +14, +18.
    n_right = 0;
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 0);
    idle(10);
    check_int("key_hold_pulses", n_right, 4);

    // Both keys held: no steps.
    n_right = 0; n_left = 0;
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1, 1);
    idle(2);
    check_int("both_keys_pulses", n_right + n_left, 0);

    // Same-cycle opposite steps cancel.
    n_right = 0; n_left = 0;
    cycle(1, 1, 0, 0, 0);
    idle(6);
    check_int("same_cycle_cancel", n_right + n_left, 0);

    // One step to occupy the gap, then right/left in consecutive cycles cancel in pend.
    n_right = 0; n_left = 0;
    cycle(0, 1, 0, 0, 0);
    idle(1);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    idle(8);
    check_int("consecutive_cancel", n_right + n_left, 1);

    // Idle timeout: edit_mode drops IDLE_TO cycles after the last accepted step.
    cnt = 8;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cycle(0, 0, 0, 0, 0);
      cnt++;
      if (!edit_mode) seen = 1;
    end
    check_int("idle_timeout_cycles", cnt, IDLE_TO);
    check("idle_timeout_state", {Left_pulse, Right_pulse, edit_mode, d_pulse, pend_ovf},
          {1'b0, 1'b0, 1'b0, 1'b0, pend_ovf});

    // Exit with pend=2: nothing further is issued, and pend is found empty on re-entry.
    cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    n_right = 0;
    cycle(0, 0, 1, 0, 0);
    idle(12);
    check_int("exit_no_pulses", n_right, 0);
    check_int("exit_edit_mode", int'(edit_mode), 0);
    cycle(0, 0, 1, 0, 0);
    n_right = 0;
    idle(10);
    check_int("reentry_pend_empty", n_right, 0);

    // Reset asserted while a strobe is on the output.
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (Right_pulse) seen = 1;
    end
    check_int("burst_pulse_seen", int'(seen), 1);
    #1 rst_n = 1'b0;
    #1;
    check("reset_cuts_pulse", {Left_pulse, Right_pulse, edit_mode, d_pulse, pend_ovf}, 5'b0);
    model_reset();
    enc_right = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_right = 0; n_left = 0;
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    idle(8);
    check_int("post_reset_locked", n_right + n_left, 0);

    // Randomized traffic against the model.
    ku_s = 0; kd_s = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) ku_s = 1 - ku_s;
      if ($urandom_range(0, 29) == 0) kd_s = 1 - kd_s;
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 79) == 0, ku_s[0], kd_s[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
